uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin scheduler that shares the single UART transmitter among NUM_REQ byte producers (register-file readback, ALU results, status reports). It grants ownership of the transmitter, supports multi-byte bursts delimited by a LAST flag, and sequences the transmitter's DATA_VALID/BUSY handshake. It sits in the TX clock domain, directly in front of the UART top-level TX_D_VLD/TX_IN_P/BUSY pins.

## Interface
- DATA_WIDTH, 8, byte width; matches the UART data width
- NUM_REQ, 4, number of requesters (2..8)
- BUSY_TIMEOUT, 15, max cycles to wait for TX_BUSY to rise after a load (1..255)
- CLK  in  1  TX clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- REQ  in  NUM_REQ  requester i has a byte pending on its data slice
- REQ_DATA  in  NUM_REQ*DATA_WIDTH  byte of requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- REQ_LAST  in  NUM_REQ  byte of requester i is last of its burst
- REQ_ACK  out  NUM_REQ  one-cycle pulse: byte of requester i captured; requester may present the next byte on the following cycle
- GNT  out  NUM_REQ  one-hot current owner; all-zero when idle
- TX_D_VLD  out  1  to UART DATA_VALID; one-cycle pulse
- TX_P_DATA  out  DATA_WIDTH  to UART parallel data; held stable from load until next load
- TX_BUSY  in  1  UART busy
- TIMEOUT_ERR  out  1  one-cycle pulse: UART failed to go busy within BUSY_TIMEOUT

## Operation
- States: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
- IDLE: arbitrates only when TX_BUSY=0 and REQ!=0. Winner = first set REQ bit searching upward from (PTR+1) mod NUM_REQ with wrap. On arbitration: GNT<=onehot(winner), data/last registers <= winner's REQ_DATA/REQ_LAST, REQ_ACK[winner]<=1, TX_D_VLD<=1, TX_P_DATA<=data, go LOAD.
- LOAD (one cycle): TX_D_VLD<=0, clear timeout counter, go WAIT_BUSY.
- WAIT_BUSY: TX_BUSY=1 -> WAIT_DONE. Otherwise increment counter; when counter reaches BUSY_TIMEOUT: TIMEOUT_ERR pulse, GNT<=0, PTR<=owner, go IDLE (byte dropped; already ACKed).
- WAIT_DONE: wait TX_BUSY=0, then:
  - last=1: GNT<=0, PTR<=owner, IDLE.
  - last=0 and REQ[owner]=1: capture next byte of owner, ACK, TX_D_VLD pulse, LOAD (grant kept; other requesters wait).
  - last=0 and REQ[owner]=0: burst abandoned; GNT<=0, PTR<=owner, IDLE.
- PTR reset value NUM_REQ-1, so requester 0 has first priority after reset.
- REQ bits of non-owners are ignored until the grant is released; no preemption.
- REQ_DATA/REQ_LAST are sampled only on the capture edge.

## Timing
- All outputs registered. Reset values: GNT=0, REQ_ACK=0, TX_D_VLD=0, TX_P_DATA=0, TIMEOUT_ERR=0; state IDLE, PTR=NUM_REQ-1, counter=0.
- Latency: REQ sampled high at edge k (IDLE, TX_BUSY=0) -> during cycle k+1: GNT, REQ_ACK, TX_D_VLD=1, TX_P_DATA valid, all simultaneously.
- Burst continuation: TX_BUSY sampled low at edge m in WAIT_DONE -> next byte's ACK/TX_D_VLD in cycle m+1. Minimum gap between TX_D_VLD pulses: 3 cycles plus the UART frame time.
- Release to re-arbitration: release at edge m; earliest new grant at edge m+1 (visible cycle m+2).
- RST mid-operation: all outputs cleared at the next edge; the in-flight burst is abandoned. IDLE waits for TX_BUSY=0 before granting, so a frame still shifting out is never overrun.
- Simultaneous requests: exactly one GNT/REQ_ACK bit is ever set.

## Test plan
- Single byte: REQ=0001, REQ_DATA[7:0]=0xA5, LAST=1 -> one cycle later GNT=0001, REQ_ACK=0001, TX_D_VLD=1, TX_P_DATA=0xA5; after model BUSY 1->0, GNT=0000.
- Round-robin fairness: REQ=1111 held, all LAST=1 -> grant order 0,1,2,3,0; each GNT seen exactly once per 4 frames.
- Burst: requester 2 sends 0x11,0x22,0x33 (LAST on 0x33) while REQ=1111 -> three consecutive frames under GNT=0100, then GNT moves to 3.
- Abandoned burst: requester 1 sends 0x10 with LAST=0, then drops REQ -> GNT released after BUSY falls; requester 2 granted next.
- Timeout: TX_BUSY tied 0, single request -> TIMEOUT_ERR pulses exactly 15 cycles after the WAIT_BUSY entry; GNT=0; the next request is granted normally.
- Reset mid-burst: assert RST during WAIT_DONE with TX_BUSY=1 -> outputs 0 next edge; a pending REQ is not granted until TX_BUSY=0, then requester 0 wins.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin owner of the shared UART transmitter with burst and busy-handshake sequencing
module uart_tx_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ = 4,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          tx_d_vld,
  output logic [DATA_WIDTH-1:0]         tx_p_data,
  input  logic                          tx_busy,
  output logic                          timeout_err
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state;
  logic [IW-1:0] ptr, owner, win, idx, sel;
  logic [7:0] cnt;
  logic last, take;
  always_comb begin
    win = ptr;
    idx = ptr;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IW'((int'(ptr) + k) % NUM_REQ);
      win = req[idx] ? idx : win;
    end
  end
  assign sel = (state == IDLE) ? win : owner;
  assign take = !tx_busy && ((state == IDLE && |req) || (state == WAIT_DONE && !last && req[owner]));
  always_ff @(posedge clk) begin
    req_ack <= '0;
    tx_d_vld <= 1'b0;
    timeout_err <= 1'b0;
    if (rst) begin
      state <= IDLE;
      gnt <= '0;
      tx_p_data <= '0;
      ptr <= IW'(NUM_REQ - 1);
      owner <= '0;
      cnt <= '0;
      last <= 1'b0;
    end else if (take) begin
      owner <= sel;
      gnt <= NUM_REQ'(1) << sel;
      req_ack <= NUM_REQ'(1) << sel;
      last <= req_last[sel];
      tx_d_vld <= 1'b1;
      tx_p_data <= req_data[sel*DATA_WIDTH +: DATA_WIDTH];
      state <= LOAD;
    end else begin
      case (state)
        LOAD: begin
          cnt <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) state <= WAIT_DONE;
          else if (cnt + 8'd1 == 8'(BUSY_TIMEOUT)) begin
            timeout_err <= 1'b1;
            gnt <= '0;
            ptr <= owner;
            state <= IDLE;
          end else cnt <= cnt + 8'd1;
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            gnt <= '0;
            ptr <= owner;
            state <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: vector table, directed corner cases and randomized bursts against a transaction-level model
module tb_uart_tx_arbiter;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int BT = 15;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR-1:0] req = '0;
  logic [NR-1:0] req_last = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic tx_busy = 1'b0;
  logic [NR-1:0] req_ack, gnt;
  logic tx_d_vld, timeout_err;
  logic [DW-1:0] tx_p_data;
  always #5 clk = ~clk;
  uart_tx_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
    .req_ack(req_ack), .gnt(gnt), .tx_d_vld(tx_d_vld), .tx_p_data(tx_p_data),
    .tx_busy(tx_busy), .timeout_err(timeout_err)
  );
  int tests = 0;
  int fails = 0;
  bit auto_on = 1'b0;
  int u_wait = -1;
  int u_len = 0;
  logic [7:0] bd[NR][16];
  logic bl[NR][16];
  int nb[NR];
  int hd[NR];
  typedef struct {int id; logic [7:0] d;} frm_t;
  frm_t exq[$];
  typedef struct {logic [3:0] rq; logic [3:0] g; logic [7:0] d;} vec_t;
  vec_t tv[7];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic present();
    for (int i = 0; i < NR; i++) begin
      if (hd[i] < nb[i]) begin
        req[i] = 1'b1;
        req_data[i*DW +: DW] = bd[i][hd[i]];
        req_last[i] = bl[i][hd[i]];
      end else begin
        req[i] = 1'b0;
        req_last[i] = 1'b0;
      end
    end
  endtask
  task automatic step();
    frm_t f;
    @(posedge clk);
    #1;
    chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    chk("ack_within_gnt", 32'(req_ack & ~gnt), 32'd0);
    if (auto_on) begin
      if (tx_d_vld) begin
        chk("rand_frame_expected", 32'(exq.size() > 0), 32'd1);
        if (exq.size() > 0) begin
          f = exq.pop_front();
          chk("rand_gnt", 32'(gnt), 32'(1 << f.id));
          chk("rand_data", 32'(tx_p_data), 32'(f.d));
          chk("rand_ack", 32'(req_ack), 32'(gnt));
        end
        u_wait = $urandom_range(0, 3);
      end
      for (int i = 0; i < NR; i++) if (req_ack[i]) hd[i]++;
      present();
      if (u_wait > 0) u_wait--;
      else if (u_wait == 0) begin
        tx_busy = 1'b1;
        u_len = $urandom_range(1, 6);
        u_wait = -1;
      end else if (u_len > 0) begin
        u_len--;
        if (u_len == 0) tx_busy = 1'b0;
      end
    end
  endtask
  task automatic do_reset();
    auto_on = 1'b0;
    rst = 1'b1;
    req = '0;
    req_last = '0;
    tx_busy = 1'b0;
    u_wait = -1;
    u_len = 0;
    step();
    rst = 1'b0;
  endtask
  task automatic build_expected();
    int p;
    int w;
    int h[NR];
    logic lst;
    p = NR - 1;
    for (int i = 0; i < NR; i++) h[i] = 0;
    forever begin
      w = -1;
      for (int k = 1; k <= NR; k++) if (w < 0 && h[(p + k) % NR] < nb[(p + k) % NR]) w = (p + k) % NR;
      if (w < 0) break;
      do begin
        exq.push_back('{w, bd[w][h[w]]});
        lst = bl[w][h[w]];
        h[w]++;
      end while (!lst);
      p = w;
    end
  endtask
  initial begin
    int n;
    int bursts;
    int len;
    tv[0] = '{4'b0001, 4'b0001, 8'h11};
    tv[1] = '{4'b1111, 4'b0001, 8'h11};
    tv[2] = '{4'b1010, 4'b0010, 8'h22};
    tv[3] = '{4'b1000, 4'b1000, 8'h44};
    tv[4] = '{4'b0110, 4'b0010, 8'h22};
    tv[5] = '{4'b1100, 4'b0100, 8'h33};
    tv[6] = '{4'b0000, 4'b0000, 8'h00};
    do_reset();
    rst = 1'b1;
    step();
    chk("reset_outputs", 32'({gnt, req_ack, tx_d_vld, tx_p_data, timeout_err}), 32'd0);
    for (int v = 0; v < 7; v++) begin
      do_reset();
      req_data = 32'h44332211;
      req_last = '1;
      req = tv[v].rq;
      step();
      chk("vec_gnt", 32'(gnt), 32'(tv[v].g));
      chk("vec_ack", 32'(req_ack), 32'(tv[v].g));
      chk("vec_vld", 32'(tx_d_vld), 32'(|tv[v].g));
      chk("vec_data", 32'(tx_p_data), 32'(tv[v].d));
    end
    do_reset();
    req = 4'b0001;
    req_data = 32'h000000A5;
    req_last = 4'b0001;
    step();
    chk("single_gnt", 32'({gnt, req_ack, tx_d_vld, tx_p_data}), 32'({4'b0001, 4'b0001, 1'b1, 8'hA5}));
    req = '0;
    step();
    chk("single_vld_pulse", 32'(tx_d_vld), 32'd0);
    tx_busy = 1'b1;
    repeat (3) step();
    chk("single_hold_gnt", 32'(gnt), 32'b0001);
    tx_busy = 1'b0;
    for (int c = 0; c < 10 && gnt != 0; c++) step();
    chk("single_release", 32'(gnt), 32'd0);
    chk("single_data_held", 32'(tx_p_data), 32'hA5);
    do_reset();
    req = 4'b0001;
    req_data = 32'h0000005A;
    req_last = 4'b0001;
    step();
    chk("to_load", 32'(tx_d_vld), 32'd1);
    req = '0;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      n++;
      if (timeout_err) break;
    end
    chk("timeout_delay", 32'(n), 32'd16);
    chk("timeout_gnt", 32'(gnt), 32'd0);
    req = 4'b0011;
    req_data = 32'h00007700;
    step();
    chk("timeout_pulse", 32'(timeout_err), 32'd0);
    chk("after_timeout_gnt", 32'(gnt), 32'b0010);
    chk("after_timeout_data", 32'(tx_p_data), 32'h77);
    do_reset();
    req = 4'b0110;
    req_data = 32'h00201000;
    req_last = 4'b0100;
    step();
    chk("abandon_first", 32'({gnt, tx_p_data}), 32'({4'b0010, 8'h10}));
    req = 4'b0100;
    step();
    tx_busy = 1'b1;
    repeat (3) step();
    tx_busy = 1'b0;
    for (int c = 0; c < 10 && gnt != 0; c++) step();
    chk("abandon_release", 32'({gnt, tx_d_vld}), 32'd0);
    step();
    chk("abandon_next", 32'({gnt, tx_d_vld, tx_p_data}), 32'({4'b0100, 1'b1, 8'h20}));
    do_reset();
    req = 4'b0100;
    req_data = 32'h00330099;
    req_last = 4'b0000;
    step();
    chk("rstmid_gnt", 32'(gnt), 32'b0100);
    step();
    tx_busy = 1'b1;
    repeat (2) step();
    rst = 1'b1;
    step();
    chk("rstmid_outputs", 32'({gnt, req_ack, tx_d_vld, tx_p_data, timeout_err}), 32'd0);
    rst = 1'b0;
    req = 4'b0101;
    repeat (3) step();
    chk("rstmid_wait_busy", 32'(gnt), 32'd0);
    tx_busy = 1'b0;
    step();
    chk("rstmid_gnt0", 32'({gnt, tx_p_data}), 32'({4'b0001, 8'h99}));
    for (int r = 0; r < 6; r++) begin
      do_reset();
      step();
      for (int i = 0; i < NR; i++) begin
        nb[i] = 0;
        hd[i] = 0;
        bursts = (r == 0) ? 2 : $urandom_range(0, 3);
        for (int b = 0; b < bursts; b++) begin
          len = (r == 0) ? 1 : $urandom_range(1, 3);
          for (int j = 0; j < len; j++) begin
            bd[i][nb[i]] = 8'($urandom);
            bl[i][nb[i]] = (j == len - 1);
            nb[i]++;
          end
        end
      end
      exq.delete();
      build_expected();
      present();
      auto_on = 1'b1;
      for (int c = 0; c < 3000 && (exq.size() > 0 || gnt != 0 || tx_busy); c++) step();
      chk("rand_drained", 32'(exq.size()), 32'd0);
      chk("rand_idle_gnt", 32'(gnt), 32'd0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
